// File: rtl/fill_dreg.sv
// One-deep valid/ready output register: loads when the consumer side is free,
// empties when drained without a new load, and holds everything under backpressure.
module fill_dreg #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         free_o,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // Free when empty or when the current token leaves this cycle.
   assign free_o = !valid_q || ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/valve_fill.sv
// Re-densifies a valved stream: each condition token yields one output token,
// forwarding din on cond=1 and repeating the last forwarded value on cond=0.
module valve_fill #(
   parameter int             DIN   = 16,
   parameter logic [DIN-1:0] INIT  = '0,
   parameter int             CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cond_valid,
   input  logic             cond_data,
   output logic             cond_ready,
   input  logic             din_valid,
   input  logic [DIN-1:0]   din_data,
   output logic             din_ready,
   output logic             dout_valid,
   output logic [DIN-1:0]   dout_data,
   input  logic             dout_ready,
   output logic [CNT_W-1:0] fill_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   logic             load;
   logic             go;
   logic [DIN-1:0]   next_data;
   logic [DIN-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A cond=1 token only moves together with its din token.
   assign go         = cond_valid && load && (!cond_data || din_valid);
   assign cond_ready = go;
   assign din_ready  = cond_valid && cond_data && load && din_valid;
   assign next_data  = cond_data ? din_data : hold_q;

   always_comb begin
      hold_d = hold_q;
      cnt_d  = cnt_q;
      if (go) begin
         if (cond_data) hold_d = din_data;
         else           cnt_d  = sat_inc(cnt_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= INIT;
         cnt_q  <= '0;
      end else begin
         hold_q <= hold_d;
         cnt_q  <= cnt_d;
      end
   end

   fill_dreg #(.W(DIN)) u_dreg (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (go),
      .data_i  (next_data),
      .ready_i (dout_ready),
      .free_o  (load),
      .valid_o (dout_valid),
      .data_o  (dout_data)
   );

   assign fill_cnt = cnt_q;

endmodule
